// File: rtl/fetch_decode_queue_if.sv
// Handshake bundle between the fetch unit, the prefetch queue and the decode stage.
// The queue takes the slave view; the fetch/decode side (or a bench) takes the master view.
interface fetch_decode_queue_if #(
    parameter int ADDR_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [31:0]       in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic [31:0]       out_pc4;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_pc4, count, full, empty
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_pc4, count, full, empty
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// Instruction prefetch queue: circular buffer of {instr, pc} entries between fetch and decode.
// A redirect (flush) empties the queue; outputs read the head entry combinationally.
module fetch_decode_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_decode_queue_if.slave   q
);
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
    localparam logic [ADDR_W:0]   COUNT_ONE = 1;
    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W+1)'(DEPTH);

    logic [63:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic [63:0]       head;
    logic              push;
    logic              pop;

    // Ready and valid come only from registered count, so there is no ready-from-ready path.
    assign q.full     = (count_q == COUNT_MAX);
    assign q.empty    = (count_q == '0);
    assign q.in_ready = !q.full;
    assign q.out_valid = !q.empty;
    assign q.count    = count_q;

    assign push = q.in_valid && q.in_ready && !q.flush;
    assign pop  = q.out_valid && q.out_ready && !q.flush;

    // NOTE: storage is deliberately not reset; count gates every read, so stale data never escapes.
    always_ff @(posedge clk) begin
        if (push) begin
            // NOTE: non-blocking assignments for all sequential state, so every register samples pre-edge values.
            mem[wr_ptr] <= {q.in_instr, q.in_pc};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || q.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + COUNT_ONE;
                2'b01:   count_q <= count_q - COUNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // An empty queue presents a nop at PC 0 rather than whatever the head slot last held.
    assign head        = mem[rd_ptr];
    assign q.out_instr = q.out_valid ? head[63:32]          : 32'h0000_0000;
    assign q.out_pc    = q.out_valid ? head[31:0]           : 32'h0000_0000;
    assign q.out_pc4   = q.out_valid ? head[31:0] + 32'd4   : 32'h0000_0000;
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_decode_queue;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    entry_t model[$];

    fetch_decode_queue_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_decode_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (bus)
    );

    always #5 clk = ~clk;

    // Reference model expectations, derived from the queue contents alone.
    function automatic logic [31:0] exp_instr();
        return (model.size() != 0) ? model[0].instr : 32'h0;
    endfunction
    function automatic logic [31:0] exp_pc();
        return (model.size() != 0) ? model[0].pc : 32'h0;
    endfunction
    function automatic logic [31:0] exp_pc4();
        return (model.size() != 0) ? model[0].pc + 32'd4 : 32'h0;
    endfunction

    // Apply one cycle of stimulus, advance the model with the queue rules, sample #1 after the edge.
    task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic ordy, input logic rst);
        bit do_push, do_pop;
        bus.in_valid  = iv;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.flush     = fl;
        bus.out_ready = ordy;
        reset         = rst;
        @(posedge clk);
        if (rst || fl) begin
            model.delete();
        end else begin
            do_push = iv && (model.size() < DEPTH);
            do_pop  = ordy && (model.size() > 0);
            if (do_pop)  void'(model.pop_front());
            if (do_push) model.push_back('{instr: ins, pc: pc});
        end
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'hDEAD_BEEF, 32'h1234, 1'b0, 1'b1, 1'b1);
        idle();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin failures++; $display("FAIL reset_flags empty=%b full=%b exp 1/0", bus.empty, bus.full); end
        checks++; if ({bus.out_instr, bus.out_pc, bus.out_pc4} !== 96'h0) begin failures++; $display("FAIL reset_outputs got=%h/%h/%h exp=0/0/0", bus.out_instr, bus.out_pc, bus.out_pc4); end
    endtask

    task automatic test_fill_drain();
        for (int k = 0; k < 4; k++)
            drive(1'b1, 32'h2401_0001 + 32'(k), 32'h3000 + 32'(4*k), 1'b0, 1'b0, 1'b0);
        checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", bus.count); end
        checks++; if (bus.full !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL fill_full full=%b in_ready=%b exp 1/0", bus.full, bus.in_ready); end
        drive(1'b1, 32'h2401_0005, 32'h3010, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.count !== 3'd4 || bus.out_pc !== 32'h3000) begin failures++; $display("FAIL fill_overflow count=%0d pc=%h exp 4/00003000", bus.count, bus.out_pc); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.out_pc !== 32'h3000 + 32'(4*k) || bus.out_pc4 !== 32'h3004 + 32'(4*k)
                || bus.out_instr !== 32'h2401_0001 + 32'(k)) begin
                failures++;
                $display("FAIL drain_%0d pc=%h pc4=%h instr=%h exp %h/%h/%h", k, bus.out_pc, bus.out_pc4,
                         bus.out_instr, 32'h3000 + 32'(4*k), 32'h3004 + 32'(4*k), 32'h2401_0001 + 32'(k));
            end
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        end
        checks++; if (bus.empty !== 1'b1 || bus.out_pc !== 32'h0) begin failures++; $display("FAIL drain_empty empty=%b pc=%h exp 1/0", bus.empty, bus.out_pc); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'hA000_0000, 32'h5000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hA000_0001, 32'h5004, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.out_pc !== 32'h5000 + 32'(4*k)) begin failures++; $display("FAIL b2b_head_%0d got=%h exp=%h", k, bus.out_pc, 32'h5000 + 32'(4*k)); end
            drive(1'b1, 32'hA000_0002 + 32'(k), 32'h5008 + 32'(4*k), 1'b0, 1'b1, 1'b0);
            checks++;
            if (bus.count !== 3'd2) begin failures++; $display("FAIL b2b_count_%0d got=%0d exp=2", k, bus.count); end
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bus.out_pc !== 32'h500C + 32'(4*k)) begin failures++; $display("FAIL b2b_tail_%0d got=%h exp=%h", k, bus.out_pc, 32'h500C + 32'(4*k)); end
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++)
            drive(1'b1, 32'hB000_0000 + 32'(k), 32'h7000 + 32'(4*k), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hBBBB_BBBB, 32'h7FFC, 1'b1, 1'b1, 1'b0);
        checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0) begin failures++; $display("FAIL flush_clear count=%0d valid=%b pc=%h exp 0/0/0", bus.count, bus.out_valid, bus.out_pc); end
        drive(1'b1, 32'h2401_0040, 32'h4000, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.count !== 3'd1 || bus.out_pc !== 32'h4000 || bus.out_pc4 !== 32'h4004) begin failures++; $display("FAIL flush_repush count=%0d pc=%h pc4=%h exp 1/4000/4004", bus.count, bus.out_pc, bus.out_pc4); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        checks++; if (bus.empty !== 1'b1 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_empty empty=%b in_ready=%b exp 1/1", bus.empty, bus.in_ready); end
    endtask

    task automatic test_wrap();
        int next_exp = 0;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h3000 + 32'(4*next_exp)) begin
                    failures++;
                    $display("FAIL wrap_%0d valid=%b pc=%h exp 1/%h", k, bus.out_valid, bus.out_pc, 32'h3000 + 32'(4*next_exp));
                end
                next_exp++;
            end
            drive(k < 10, 32'h2400_0000 + 32'(k), 32'h3000 + 32'(4*k), 1'b0, k > 0, 1'b0);
        end
        checks++; if (next_exp !== 10 || bus.empty !== 1'b1) begin failures++; $display("FAIL wrap_total delivered=%0d empty=%b exp 10/1", next_exp, bus.empty); end
    endtask

    task automatic test_pc4_carry();
        drive(1'b1, 32'h1234_5678, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.out_pc4 !== 32'h0 || bus.out_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL pc4_carry pc=%h pc4=%h exp fffffffc/0", bus.out_pc, bus.out_pc4); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++)
            drive(1'b1, 32'hC000_0000 + 32'(k), 32'h8000 + 32'(4*k), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hCCCC_CCCC, 32'h8FFC, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1
            || {bus.out_instr, bus.out_pc, bus.out_pc4} !== 96'h0) begin
            failures++;
            $display("FAIL reset_mid count=%0d valid=%b ready=%b instr=%h pc=%h exp 0/0/1/0/0",
                     bus.count, bus.out_valid, bus.in_ready, bus.out_instr, bus.out_pc);
        end
        drive(1'b1, 32'h2401_0060, 32'h6000, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.out_pc !== 32'h6000 || bus.out_instr !== 32'h2401_0060) begin failures++; $display("FAIL reset_mid_push pc=%h instr=%h exp 6000/24010060", bus.out_pc, bus.out_instr); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 2) == 0, 1'b0);
            checks++;
            if (bus.count !== 3'(model.size()) || bus.out_valid !== (model.size() != 0)
                || bus.in_ready !== (model.size() < DEPTH) || bus.out_instr !== exp_instr()
                || bus.out_pc !== exp_pc() || bus.out_pc4 !== exp_pc4()) begin
                failures++;
                if (bad++ < 10)
                    $display("FAIL random_%0d count=%0d valid=%b pc=%h instr=%h exp %0d/%b/%h/%h", n,
                             bus.count, bus.out_valid, bus.out_pc, bus.out_instr,
                             model.size(), model.size() != 0, exp_pc(), exp_instr());
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b0; reset = 1'b1;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_pc4_carry();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
